// File: rtl/sel_pipe_if.sv
// Handshake bundle between an upstream producer, the selector, and its consumer.
// The master side drives beats and consumes results; the slave side is the selector.
interface sel_pipe_if #(
   parameter int DATA_W = 32,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = 2,
   parameter int ERR_W  = 8
) ();
   logic                     in_valid;
   logic                     in_ready;
   logic [SEL_W-1:0]         in_sel;
   logic [NUM_IN*DATA_W-1:0] in_data;
   logic                     flush;
   logic                     out_valid;
   logic                     out_ready;
   logic [DATA_W-1:0]        out_data;
   logic                     out_sel_err;
   logic [ERR_W-1:0]         err_cnt;

   modport master (
      output in_valid, in_sel, in_data, flush, out_ready,
      input  in_ready, out_valid, out_data, out_sel_err, err_cnt
   );

   modport slave (
      input  in_valid, in_sel, in_data, flush, out_ready,
      output in_ready, out_valid, out_data, out_sel_err, err_cnt
   );
endinterface

// File: rtl/sel_pipe_mux.sv
// Registered N-way operand selector with a two-entry skid buffer on a valid/ready
// stream. Illegal selects replay the last legal word, are flagged per beat and
// counted in a saturating counter.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_EMPTY | no beat held; output and skid stages both empty
// ST_ONE   | output stage holds a beat, skid empty
// ST_FULL  | output and skid both hold beats; upstream is stalled
module sel_pipe_mux #(
   parameter int DATA_W = 32,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = 2,
   parameter int ERR_W  = 8
) (
   input logic     clk,
   input logic     rst_n,
   sel_pipe_if.slave bus
);

   // bit 0 = output stage valid, bit 1 = skid stage valid
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_FULL  = 2'b11
   } state_t;

   localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

   state_t            state;
   state_t            state_n;
   logic              in_ready_q;
   logic              accept;
   logic              sel_legal;
   logic [DATA_W-1:0] sel_word;
   logic [DATA_W-1:0] beat_data;
   logic              load_out;
   logic              load_skid;
   logic              skid_to_out;
   logic [DATA_W-1:0] out_data_q;
   logic              out_err_q;
   logic [DATA_W-1:0] skid_data_q;
   logic              skid_err_q;
   logic [DATA_W-1:0] last_good_q;
   logic [ERR_W-1:0]  err_cnt_q;

   // Flush wins over any beat offered in the same cycle.
   assign accept = bus.in_valid && in_ready_q && !bus.flush;

   // Decode the select; anything at or beyond NUM_IN is illegal and replays last_good.
   always_comb begin
      sel_word  = '0;
      sel_legal = 1'b0;
      for (int k = 0; k < NUM_IN; k++) begin
         if (bus.in_sel == SEL_W'(k)) begin
            sel_word  = bus.in_data[k*DATA_W +: DATA_W];
            sel_legal = 1'b1;
         end
      end
      beat_data = sel_legal ? sel_word : last_good_q;
   end

   // Next-state and stage-move decisions.
   always_comb begin
      state_n     = state;
      load_out    = 1'b0;
      load_skid   = 1'b0;
      skid_to_out = 1'b0;
      if (bus.flush) begin
         state_n = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (accept) begin
                  load_out = 1'b1;
                  state_n  = ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept && bus.out_ready) begin
                  load_out = 1'b1;
               end else if (accept) begin
                  load_skid = 1'b1;
                  state_n   = ST_FULL;
               end else if (bus.out_ready) begin
                  state_n = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (bus.out_ready) begin
                  skid_to_out = 1'b1;
                  state_n     = ST_ONE;
               end
            end
            default: state_n = ST_EMPTY;
         endcase
      end
   end

   // State register; in_ready is registered from the next skid occupancy so it
   // never has a combinational path from out_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state      <= state_n;
         in_ready_q <= !state_n[1];
      end
   end

   // Output and skid data stages; contents only move on load, so they stay stable while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_err_q   <= 1'b0;
         skid_data_q <= '0;
         skid_err_q  <= 1'b0;
      end else begin
         if (load_out) begin
            out_data_q <= beat_data;
            out_err_q  <= !sel_legal;
         end else if (skid_to_out) begin
            out_data_q <= skid_data_q;
            out_err_q  <= skid_err_q;
         end
         if (load_skid) begin
            skid_data_q <= beat_data;
            skid_err_q  <= !sel_legal;
         end
      end
   end

   // last_good tracks accepted legal words; err_cnt saturates. Both survive flush.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_good_q <= '0;
         err_cnt_q   <= '0;
      end else if (accept) begin
         if (sel_legal) begin
            last_good_q <= sel_word;
         end else if (err_cnt_q != ERR_MAX) begin
            err_cnt_q <= err_cnt_q + 1'b1;
         end
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = state[0];
   assign bus.out_data    = out_data_q;
   assign bus.out_sel_err = out_err_q;
   assign bus.err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_sel_pipe_mux.sv
// Scoreboard bench for sel_pipe_mux: a reference model pushes expected beats on
// every accept, a monitor pops and compares on every output handshake.
module tb_sel_pipe_mux;
   localparam int DATA_W = 16;
   localparam int NUM_IN = 3;
   localparam int SEL_W  = 2;
   localparam int ERR_W  = 8;
   localparam int IN_W   = NUM_IN * DATA_W;
   localparam int ERR_CAP = (1 << ERR_W) - 1;

   typedef struct packed {
      logic [DATA_W-1:0] d;
      logic              e;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   beat_t             q[$];
   logic [DATA_W-1:0] lg;
   int                merr;

   sel_pipe_if #(.DATA_W(DATA_W), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .ERR_W(ERR_W)) bus ();

   sel_pipe_mux #(.DATA_W(DATA_W), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .ERR_W(ERR_W)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DATA_W-1:0] src_word(logic [SEL_W-1:0] sel, logic [IN_W-1:0] d);
      logic [IN_W-1:0] sh;
      sh = d >> (int'(sel) * DATA_W);
      return sh[DATA_W-1:0];
   endfunction

   // Reference model: every accepted beat becomes one expected output, in order.
   initial begin
      lg   = '0;
      merr = 0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            q.delete();
            lg   = '0;
            merr = 0;
         end else if (bus.flush) begin
            q.delete();
         end else if (bus.in_valid && bus.in_ready) begin
            if (int'(bus.in_sel) < NUM_IN) begin
               q.push_back(beat_t'{d: src_word(bus.in_sel, bus.in_data), e: 1'b0});
               lg = src_word(bus.in_sel, bus.in_data);
            end else begin
               q.push_back(beat_t'{d: lg, e: 1'b1});
               if (merr < ERR_CAP) merr++;
            end
         end
      end
   end

   // Monitor: mid-cycle, check occupancy-derived flags and pop on a pending handshake.
   initial begin
      beat_t b;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
            chk("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
            chk("err_cnt", 64'(bus.err_cnt), 64'(merr));
            if (bus.out_valid && bus.out_ready && !bus.flush) begin
               if (q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat: got 0x%0h expected none", bus.out_data);
               end else begin
                  b = q.pop_front();
                  chk("out_data", 64'(bus.out_data), 64'(b.d));
                  chk("out_sel_err", 64'(bus.out_sel_err), 64'(b.e));
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Hold the current beat until it is accepted, bounded.
   task automatic send_wait();
      int n = 0;
      while (!bus.in_ready && n < 20) begin
         step();
         n++;
      end
      if (n == 20) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got in_ready=0 expected 1");
      end
      step();
   endtask

   initial begin
      logic [DATA_W-1:0] err_before;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_sel   = '0;
      bus.in_data  = '0;
      bus.flush    = 1'b0;
      bus.out_ready = 1'b0;
      #12;
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_data", 64'(bus.out_data), 64'd0);
      chk("rst_err_cnt", 64'(bus.err_cnt), 64'd0);
      step();
      rst_n = 1'b1;
      step();

      // Streaming with back-to-back legal selects then one illegal.
      bus.out_ready = 1'b1;
      bus.in_data   = {16'h0033, 16'h0022, 16'h0011};
      bus.in_valid  = 1'b1;
      bus.in_sel    = 2'd0;
      step();
      chk("stream_latency_valid", 64'(bus.out_valid), 64'd1);
      chk("stream_latency_data", 64'(bus.out_data), 64'h11);
      bus.in_sel = 2'd1;
      step();
      chk("stream_b2b_data", 64'(bus.out_data), 64'h22);
      bus.in_sel = 2'd2;
      step();
      bus.in_sel = 2'd3;
      step();
      chk("illegal_replay_data", 64'(bus.out_data), 64'h33);
      chk("illegal_flag", 64'(bus.out_sel_err), 64'd1);
      chk("illegal_cnt", 64'(bus.err_cnt), 64'd1);
      bus.in_valid = 1'b0;
      step();
      step();

      // Backpressure: A to output, B to skid, C stalls until the consumer drains.
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_sel    = 2'd0;
      bus.in_data   = {16'h0CCC, 16'h0BBB, 16'h0AAA};
      step();
      chk("bp_hold_a", 64'(bus.out_data), 64'hAAA);
      bus.in_sel = 2'd1;
      step();
      chk("bp_in_ready_drop", 64'(bus.in_ready), 64'd0);
      bus.in_sel = 2'd2;
      step();
      bus.in_data = {16'h0CCC, 16'h0EEE, 16'h0DDD};
      step();
      chk("bp_still_a", 64'(bus.out_data), 64'hAAA);
      bus.out_ready = 1'b1;
      send_wait();
      bus.in_valid = 1'b0;
      repeat (3) step();

      // Flush in FULL with a simultaneous illegal beat.
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = {16'h0303, 16'h0202, 16'h0101};
      bus.in_sel    = 2'd0;
      step();
      bus.in_sel = 2'd1;
      step();
      err_before = DATA_W'(merr);
      bus.in_sel = 2'd3;
      bus.flush  = 1'b1;
      step();
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
      chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
      chk("flush_err_kept", 64'(bus.err_cnt), 64'(err_before));
      bus.out_ready = 1'b1;
      repeat (2) step();

      // Saturation of the illegal-select counter.
      bus.in_valid = 1'b1;
      bus.in_sel   = 2'd3;
      repeat (300) step();
      bus.in_valid = 1'b0;
      step();
      chk("err_saturated", 64'(bus.err_cnt), 64'hFF);

      // Async reset in the middle of a stream.
      bus.in_valid = 1'b1;
      bus.in_sel   = 2'd2;
      repeat (3) step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_out_valid", 64'(bus.out_valid), 64'd0);
      chk("async_out_data", 64'(bus.out_data), 64'd0);
      chk("async_err_cnt", 64'(bus.err_cnt), 64'd0);
      bus.in_valid = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      bus.in_valid = 1'b1;
      bus.in_sel   = 2'd3;
      step();
      bus.in_valid = 1'b0;
      chk("post_rst_valid", 64'(bus.out_valid), 64'd1);
      chk("post_rst_data", 64'(bus.out_data), 64'd0);
      chk("post_rst_flag", 64'(bus.out_sel_err), 64'd1);
      chk("post_rst_cnt", 64'(bus.err_cnt), 64'd1);
      step();

      // Random traffic against the scoreboard.
      for (int i = 0; i < 10000; i++) begin
         bus.in_valid  = ($urandom_range(0, 9) < 7);
         bus.out_ready = ($urandom_range(0, 9) < 6);
         bus.in_sel    = SEL_W'($urandom_range(0, 3));
         bus.in_data   = IN_W'({$urandom(), $urandom()});
         bus.flush     = ($urandom_range(0, 49) == 0);
         step();
      end

      bus.in_valid  = 1'b0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      repeat (4) step();
      chk("drain_empty", 64'(q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
